// File: rtl/mc_datapath_pkg.sv
// Shared FSM states, instruction encodings and ALU operations for the multi-cycle datapath.
package mc_datapath_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BLT    = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // memF3 selects the only legal load/store width for the configured XLEN.
    function automatic logic isLegal(input logic [31:0] ir, input logic [2:0] memF3);
        logic ok;
        ok = 1'b0;
        case (ir[6:0])
            OPC_OP: ok = (ir[31:25] == F7_BASE && (ir[14:12] == F3_ADDSUB || ir[14:12] == F3_SLT ||
                                                 ir[14:12] == F3_OR || ir[14:12] == F3_AND)) ||
                         (ir[31:25] == F7_SUB && ir[14:12] == F3_ADDSUB);
            OPC_OPIMM:           ok = (ir[14:12] == F3_ADDI);
            OPC_LOAD, OPC_STORE: ok = (ir[14:12] == memF3);
            OPC_BRANCH:          ok = (ir[14:12] == F3_BEQ || ir[14:12] == F3_BLT);
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_e rTypeOp(input logic [2:0] f3, input logic [6:0] f7);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADDSUB: op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            F3_SLT:    op = ALU_SLT;
            F3_OR:     op = ALU_OR;
            F3_AND:    op = ALU_AND;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle datapath, plus the equality and signed-less-than flags used by branches.
module mc_alu
    import mc_datapath_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         aluOp_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            eq_o,
    output logic            lt_o
);

    always_comb begin
        eq_o     = (a_i == b_i);
        lt_o     = ($signed(a_i) < $signed(b_i));
        result_o = '0;
        case (aluOp_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, lt_o};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath for a small RISC-V subset, with an absorbing illegal-instruction trap.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_valid,
    output logic [XLEN-1:0] pc,
    output logic            trap
);

    localparam int              RIDX_W  = $clog2(NREGS);
    localparam logic [2:0]      MEM_F3  = (XLEN == 64) ? F3_DWORD : F3_WORD;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              trap_q, trap_d;
    logic [31:0]       ir_q;
    logic [XLEN-1:0]   a_q, b_q, imm_q, aluOut_q, mdr_q;
    logic [XLEN-1:0]   regFile_q [NREGS];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [RIDX_W-1:0] rs1Idx, rs2Idx, rdIdx;
    logic              isLoad, isStore, isBranch, isRType;
    logic [XLEN-1:0]   rs1Val, rs2Val, immDec, aluB, aluRes, wbData;
    alu_op_e           aluOp;
    logic              aluEq, aluLt, branchTaken;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign funct7   = ir_q[31:25];
    assign rs1Idx   = ir_q[15 +: RIDX_W];
    assign rs2Idx   = ir_q[20 +: RIDX_W];
    assign rdIdx    = ir_q[7 +: RIDX_W];
    assign isLoad   = (opcode == OPC_LOAD);
    assign isStore  = (opcode == OPC_STORE);
    assign isBranch = (opcode == OPC_BRANCH);
    assign isRType  = (opcode == OPC_OP);

    assign rs1Val = (rs1Idx == '0) ? '0 : regFile_q[rs1Idx];
    assign rs2Val = (rs2Idx == '0) ? '0 : regFile_q[rs2Idx];

    always_comb begin
        immDec = '0;
        case (opcode)
            OPC_OPIMM, OPC_LOAD: immDec = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
            OPC_STORE:           immDec = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OPC_BRANCH:          immDec = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            default:             immDec = '0;
        endcase
    end

    // Branches compare A against B; everything that is not R-type adds the immediate.
    assign aluOp       = isRType ? rTypeOp(funct3, funct7) : ALU_ADD;
    assign aluB        = (isRType || isBranch) ? b_q : imm_q;
    assign branchTaken = (funct3 == F3_BLT) ? aluLt : aluEq;
    assign wbData      = isLoad ? mdr_q : aluOut_q;

    mc_alu #(.XLEN(XLEN)) u_alu (
        .aluOp_i  (aluOp),
        .a_i      (a_q),
        .b_i      (aluB),
        .result_o (aluRes),
        .eq_o     (aluEq),
        .lt_o     (aluLt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        trap_d  = trap_q;
        case (state_q)
            ST_FETCH: if (imem_valid) state_d = ST_DECODE;
            ST_DECODE: begin
                if (isLegal(ir_q, MEM_F3)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (isBranch) begin
                    pc_d    = branchTaken ? pc_q + imm_q : pc_q + PC_STEP;
                    state_d = ST_FETCH;
                end else if (isLoad || isStore) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_valid) begin
                    if (isLoad) begin
                        state_d = ST_WB;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                pc_d    = pc_q + PC_STEP;
                state_d = ST_FETCH;
            end
            ST_TRAP: trap_d = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            trap_q   <= 1'b0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            aluOut_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
            case (state_q)
                ST_FETCH: if (imem_valid) ir_q <= imem_rdata;
                ST_DECODE: begin
                    a_q   <= rs1Val;
                    b_q   <= rs2Val;
                    imm_q <= immDec;
                end
                ST_EXEC: aluOut_q <= aluRes;
                ST_MEM:  if (dmem_valid && isLoad) mdr_q <= dmem_rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
        end else if (state_q == ST_WB && rdIdx != '0) begin
            regFile_q[rdIdx] <= wbData;
        end
    end

    // Requests are gated by rst so an in-flight access drops the moment reset asserts.
    assign imem_req   = (state_q == ST_FETCH) && !rst;
    assign dmem_req   = (state_q == ST_MEM) && !rst;
    assign dmem_we    = dmem_req && isStore;
    assign imem_addr  = pc_q;
    assign dmem_addr  = aluOut_q;
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a table of ALU programs observed through stores, plus hand-written multi-cycle sequences.
module tb_mc_datapath;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

    logic        clk, rst, rst64;
    logic        imemReq, imemValid, dmemReq, dmemWe, dmemValid, trapOut;
    logic [31:0] imemAddr, imemRdata, dmemAddr, dmemWdata, dmemRdata, pcOut;
    logic        imem64Req, imem64Valid, dmem64Req, dmem64We, dmem64Valid, trap64;
    logic [63:0] imem64Addr, dmem64Addr, dmem64Wdata, dmem64Rdata, pc64;
    logic [31:0] imem64Rdata;

    logic [31:0] prog [0:63];
    logic [31:0] prog64 [0:15];
    logic [31:0] dataMem [0:15];
    int          dmemDelay;
    int          waitCnt = 0;
    int          stCount = 0;
    int          st64Count = 0;
    logic [31:0] lastStAddr, lastStData;
    logic [63:0] lastSt64Addr, lastSt64Data;
    logic        imemForce, dmemForce;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        string       name;
        int          opA;
        int          opB;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] expVal;
    } vec_t;
    vec_t vecs [8];

    mc_datapath #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdata), .imem_valid(imemValid),
        .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata),
        .dmem_rdata(dmemRdata), .dmem_valid(dmemValid), .pc(pcOut), .trap(trapOut)
    );

    mc_datapath #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst64),
        .imem_req(imem64Req), .imem_addr(imem64Addr), .imem_rdata(imem64Rdata), .imem_valid(imem64Valid),
        .dmem_req(dmem64Req), .dmem_we(dmem64We), .dmem_addr(dmem64Addr), .dmem_wdata(dmem64Wdata),
        .dmem_rdata(dmem64Rdata), .dmem_valid(dmem64Valid), .pc(pc64), .trap(trap64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responders: zero-wait instruction side, data side delayed by dmemDelay cycles.
    assign imemRdata   = prog[imemAddr[7:2]];
    assign imemValid   = imemReq || imemForce;
    assign dmemValid   = (dmemReq && (waitCnt >= dmemDelay)) || dmemForce;
    assign dmemRdata   = dataMem[dmemAddr[5:2]];
    assign imem64Rdata = prog64[imem64Addr[5:2]];
    assign imem64Valid = imem64Req;
    assign dmem64Valid = dmem64Req;
    assign dmem64Rdata = '0;

    always @(posedge clk) begin
        if (dmemReq && !dmemValid) waitCnt <= waitCnt + 1;
        else                       waitCnt <= 0;
        if (dmemReq && dmemWe && dmemValid) begin
            dataMem[dmemAddr[5:2]] <= dmemWdata;
            lastStAddr <= dmemAddr;
            lastStData <= dmemWdata;
            stCount    <= stCount + 1;
        end
        if (dmem64Req && dmem64We) begin
            lastSt64Addr <= dmem64Addr;
            lastSt64Data <= dmem64Wdata;
            st64Count    <= st64Count + 1;
        end
    end

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] encI(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
        logic [11:0] i12;
        i12 = imm[11:0];
        return {i12, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] encS(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        logic [11:0] s12;
        s12 = imm[11:0];
        return {s12[11:5], rs2, rs1, f3, s12[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] encB(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        logic [12:0] b13;
        b13 = imm[12:0];
        return {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], OP_BR};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 64; i++) prog[i] = ILLEGAL;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitStore(input int target, output bit ok);
        ok = (stCount >= target);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (stCount >= target);
        end
    endtask

    // Waits for the next data request and counts how many mid-cycle samples it stays up.
    task automatic measureRun(output int len, output logic [31:0] addr0, output logic we0, output bit stable);
        logic [31:0] wd0;
        len = 0;
        stable = 1'b1;
        for (int i = 0; i < 100 && !dmemReq; i++) @(negedge clk);
        addr0 = dmemAddr;
        we0   = dmemWe;
        wd0   = dmemWdata;
        while (dmemReq && len < 100) begin
            if (dmemAddr !== addr0 || dmemWe !== we0 || dmemWdata !== wd0) stable = 1'b0;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          ok, sawReq, pcMoved, stable;
        int          base, len;
        logic [31:0] addr0;
        logic        we0;

        rst = 1'b1;
        rst64 = 1'b1;
        imemForce = 1'b0;
        dmemForce = 1'b0;
        dmemDelay = 0;
        for (int i = 0; i < 16; i++) prog64[i] = ILLEGAL;

        vecs[0] = '{"add",      5,     -3,    7'h00, 3'b000, 64'h0000_0002};
        vecs[1] = '{"sub",      5,     -3,    7'h20, 3'b000, 64'h0000_0008};
        vecs[2] = '{"and",      6,      3,    7'h00, 3'b111, 64'h0000_0002};
        vecs[3] = '{"or",       6,      3,    7'h00, 3'b110, 64'h0000_0007};
        vecs[4] = '{"slt_neg", -3,      5,    7'h00, 3'b010, 64'h0000_0001};
        vecs[5] = '{"slt_pos",  5,     -3,    7'h00, 3'b010, 64'h0000_0000};
        vecs[6] = '{"sub_wrap", 0,      1,    7'h20, 3'b000, 64'hFFFF_FFFF};
        vecs[7] = '{"add_min", -2048, -2048,  7'h00, 3'b000, 64'hFFFF_F000};

        for (int v = 0; v < 8; v++) begin
            clearProgram();
            prog[0] = encI(vecs[v].opA, 5'd0, 3'b000, 5'd1, OP_IMM);
            prog[1] = encI(vecs[v].opB, 5'd0, 3'b000, 5'd2, OP_IMM);
            prog[2] = encR(vecs[v].f7, 5'd2, 5'd1, vecs[v].f3, 5'd3);
            prog[3] = encS(0, 5'd3, 5'd0, 3'b010);
            base = stCount;
            resetDut();
            waitStore(base + 1, ok);
            checkOutput({vecs[v].name, "_done"}, 64'(ok), 64'd1);
            checkOutput(vecs[v].name, 64'(lastStData), vecs[v].expVal);
        end

        // ADDI/ADDI/ADD timing: four cycles per instruction from the first fetch.
        clearProgram();
        prog[0] = encI(5, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1] = encI(-3, 5'd0, 3'b000, 5'd2, OP_IMM);
        prog[2] = encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3] = encS(0, 5'd3, 5'd0, 3'b010);
        rst = 1'b1;
        #1;
        checkOutput("rst_trap", 64'(trapOut), 64'd0);
        checkOutput("rst_pc", 64'(pcOut), 64'd0);
        checkOutput("rst_imem_req", 64'(imemReq), 64'd0);
        checkOutput("rst_dmem_req", 64'(dmemReq), 64'd0);
        base = stCount;
        resetDut();
        #1;
        checkOutput("first_imem_req", 64'(imemReq), 64'd1);
        applyStimulus(3);
        checkOutput("seq_pc_3cyc", 64'(pcOut), 64'd0);
        applyStimulus(1);
        checkOutput("seq_pc_4cyc", 64'(pcOut), 64'd4);
        applyStimulus(4);
        checkOutput("seq_pc_8cyc", 64'(pcOut), 64'd8);
        applyStimulus(4);
        checkOutput("seq_pc_12cyc", 64'(pcOut), 64'd12);
        waitStore(base + 1, ok);
        checkOutput("seq_x3_done", 64'(ok), 64'd1);
        checkOutput("seq_x3", 64'(lastStData), 64'd2);

        // Store then load with three wait cycles on the data side.
        clearProgram();
        prog[0] = encI(5, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1] = encS(0, 5'd1, 5'd0, 3'b010);
        prog[2] = encI(0, 5'd0, 3'b010, 5'd4, OP_LOAD);
        prog[3] = encS(4, 5'd4, 5'd0, 3'b010);
        dmemDelay = 3;
        base = stCount;
        resetDut();
        measureRun(len, addr0, we0, stable);
        checkOutput("sw_req_len", 64'(len), 64'd4);
        checkOutput("sw_addr", 64'(addr0), 64'd0);
        checkOutput("sw_we", 64'(we0), 64'd1);
        checkOutput("sw_stable", 64'(stable), 64'd1);
        measureRun(len, addr0, we0, stable);
        checkOutput("lw_req_len", 64'(len), 64'd4);
        checkOutput("lw_addr", 64'(addr0), 64'd0);
        checkOutput("lw_we", 64'(we0), 64'd0);
        checkOutput("lw_stable", 64'(stable), 64'd1);
        waitStore(base + 2, ok);
        checkOutput("x4_done", 64'(ok), 64'd1);
        checkOutput("x4_addr", 64'(lastStAddr), 64'd4);
        checkOutput("x4_value", 64'(lastStData), 64'd5);
        dmemDelay = 0;

        // BLT taken by +16, BEQ not taken, then an illegal word that must trap.
        clearProgram();
        prog[0] = encI(5, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1] = encI(-3, 5'd0, 3'b000, 5'd2, OP_IMM);
        prog[2] = encB(16, 5'd1, 5'd2, 3'b100);
        prog[6] = encB(8, 5'd2, 5'd1, 3'b000);
        resetDut();
        applyStimulus(8);
        checkOutput("br_pc_before", 64'(pcOut), 64'd8);
        applyStimulus(2);
        checkOutput("blt_pc_2cyc", 64'(pcOut), 64'd8);
        applyStimulus(1);
        checkOutput("blt_taken_pc", 64'(pcOut), 64'd24);
        applyStimulus(3);
        checkOutput("beq_not_taken_pc", 64'(pcOut), 64'd28);
        applyStimulus(1);
        checkOutput("trap_not_yet", 64'(trapOut), 64'd0);
        applyStimulus(1);
        checkOutput("trap_set", 64'(trapOut), 64'd1);
        imemForce = 1'b1;
        dmemForce = 1'b1;
        sawReq = 1'b0;
        pcMoved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imemReq || dmemReq) sawReq = 1'b1;
            if (pcOut !== 32'd28) pcMoved = 1'b1;
        end
        checkOutput("trap_no_req", 64'(sawReq), 64'd0);
        checkOutput("trap_pc_frozen", 64'(pcMoved), 64'd0);
        checkOutput("trap_sticky", 64'(trapOut), 64'd1);
        imemForce = 1'b0;
        dmemForce = 1'b0;

        // Reset during a long data wait abandons the store.
        clearProgram();
        prog[0] = encI(9, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1] = encS(8, 5'd1, 5'd0, 3'b010);
        dmemDelay = 10;
        base = stCount;
        resetDut();
        for (int i = 0; i < 50 && !dmemReq; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("mem_waiting", 64'(dmemReq), 64'd1);
        checkOutput("mem_wait_pc", 64'(pcOut), 64'd4);
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_dmem_req", 64'(dmemReq), 64'd0);
        checkOutput("rst_mid_imem_req", 64'(imemReq), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_imem_req", 64'(imemReq), 64'd1);
        checkOutput("rel_pc", 64'(pcOut), 64'd0);
        checkOutput("store_abandoned", 64'(stCount - base), 64'd0);
        dmemDelay = 0;

        // x0 ignores writes.
        clearProgram();
        prog[0] = encI(7, 5'd0, 3'b000, 5'd0, OP_IMM);
        prog[1] = encR(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);
        prog[2] = encS(0, 5'd5, 5'd0, 3'b010);
        base = stCount;
        resetDut();
        waitStore(base + 1, ok);
        checkOutput("x0_done", 64'(ok), 64'd1);
        checkOutput("x5_zero", 64'(lastStData), 64'd0);

        // 64-bit instance: ADDI -1 must sign-extend across all 64 bits.
        prog64[0] = encI(-1, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog64[1] = encS(8, 5'd1, 5'd0, 3'b011);
        repeat (2) @(negedge clk);
        rst64 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (st64Count >= 1);
        end
        checkOutput("x64_done", 64'(ok), 64'd1);
        checkOutput("x64_addr", lastSt64Addr, 64'd8);
        checkOutput("x64_value", lastSt64Data, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (6) @(negedge clk);
        checkOutput("x64_trap", 64'(trap64), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- XLEN, 32, data/address width; legal values 32 or 64.
- RESET_PC, 0, PC value loaded at reset.
- NREGS, 32, register count; x0 reads as 0 and ignores writes.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- imem_req, out, 1, instruction fetch request.
- imem_addr, out, XLEN, fetch address, equal to pc.
- imem_rdata, in, 32, instruction word.
- imem_valid, in, 1, imem_rdata valid this cycle.
- dmem_req, out, 1, data access request.
- dmem_we, out, 1, 1 = store, 0 = load.
- dmem_addr, out, XLEN, ALU result (rs1 + imm).
- dmem_wdata, out, XLEN, rs2 value.
- dmem_rdata, in, XLEN, load data.
- dmem_valid, in, 1, load data valid or store accepted.
- pc, out, XLEN, current instruction address.
- trap, out, 1, sticky illegal-instruction flag.

Function
REQ-003 Supported instructions SHALL be ADD, SUB, AND, OR, SLT, ADDI, LW (LD when XLEN=64), SW (SD when XLEN=64), BEQ, and BLT; any other encoding SHALL be illegal.
REQ-004 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, and TRAP, with one state per cycle unless stalled.
REQ-005 FETCH: the block SHALL hold imem_req=1 with a stable imem_addr until imem_valid=1, then latch the instruction into IR and go to DECODE.
REQ-006 DECODE: the block SHALL latch rs1, rs2, and the sign-extended immediate (I/S/B formats) into A, B, and IMM; an illegal opcode SHALL go to TRAP, otherwise the FSM SHALL go to EXEC.
REQ-007 EXEC: the block SHALL compute the ALU result into register ALUOUT.
- R-type and ADDI SHALL go to WB.
- Loads and stores SHALL go to MEM.
- Branches SHALL resolve here: on taken, pc <= pc + IMM; on not taken, pc <= pc + 4; the FSM SHALL then return to FETCH.
REQ-008 BLT SHALL use a signed comparison; SLT SHALL write 1 or 0 zero-extended to XLEN.
REQ-009 MEM: the block SHALL hold dmem_req=1 with stable dmem_addr, dmem_we, and dmem_wdata until dmem_valid=1.
- A load SHALL latch dmem_rdata into MDR and go to WB.
- A store SHALL set pc <= pc + 4 and go to FETCH.
REQ-010 WB: the block SHALL write ALUOUT (or MDR for loads) to rd, set pc <= pc + 4, and go to FETCH.
- Register writes SHALL occur only in WB, with rd=0 suppressed.
REQ-011 imem_req and dmem_req SHALL never be asserted in the same cycle, and each SHALL be 0 outside its own state.
REQ-012 Arithmetic SHALL wrap modulo 2^XLEN, and pc SHALL wrap at 2^XLEN with no fault.
REQ-013 TRAP SHALL be absorbing: trap=1, no requests issued, pc frozen; only rst exits TRAP.
REQ-014 A valid strobe arriving in a state that is not waiting for it SHALL be ignored.
REQ-015 Latency with zero-wait memories SHALL be:
- R-type and ADDI: 4 cycles.
- Branches: 3 cycles.
- Stores: 4 cycles.
- Loads: 5 cycles.

Reset
REQ-016 On rst=1 the block SHALL immediately (asynchronously) set state=FETCH, pc=RESET_PC, trap=0, and IR, A, B, IMM, ALUOUT, and MDR to 0, with all registers cleared.
REQ-017 rst asserted mid-access SHALL drop imem_req and dmem_req immediately, and a pending access SHALL be abandoned.
REQ-018 The first imem_req SHALL assert in the first cycle after rst deasserts.

Structure
REQ-019 A shared package SHALL hold the state enum, opcode/funct3/funct7 constants, and the ALU-op enum.
REQ-020 The ALU SHALL be one sub-module, mc_alu, parametrised by XLEN; the register file SHALL be inline in mc_datapath.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 (zero-wait) -> x3=2, each instruction taking 4 cycles, pc=12.
- SW x1,0(x0) then LW x4,0(x0), with dmem_valid delayed 3 cycles -> dmem_req held 4 cycles with stable address 0; x4=5.
- x1=5, x2=-3: BLT x2,x1,+16 -> pc advances by 16; BEQ x1,x2,+8 -> pc advances by 4.
- Instruction 0xFFFFFFFF -> TRAP entered; trap=1; no further imem_req; pc unchanged over 20 cycles.
- rst asserted during a MEM wait -> dmem_req=0 in the same cycle; after release, pc=RESET_PC and imem_req=1.
- ADDI x0,x0,7 then ADD x5,x0,x0 -> x5=0; with XLEN=64, ADDI x1,x0,-1 -> x1=0xFFFF_FFFF_FFFF_FFFF.
